// File: rtl/pipeline_sequencer.sv
// Pipeline sequencing controller for the 5-stage core: hazards, flushes,
// end-of-program stop, debug halt/step/resume and stall/flush statistics.
module pipeline_sequencer #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch_taken,
    input  logic             wb_end,
    input  logic             dbg_halt_req,
    input  logic             dbg_step,
    input  logic             dbg_resume,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             halted,
    output logic             ended,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED, STEP} state_t;

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

    state_t     state, state_nx;
    logic [2:0] drain_cnt, drain_nx;
    logic       ended_nx;
    logic       stall_inc, flush_inc;
    logic       load_use;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) ||
                       (id_uses_rs2 && (ex_rd == id_rs2)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            drain_cnt   <= 3'd0;
            ended       <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= drain_nx;
            ended     <= ended_nx;
            if (stall_inc && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
            if (flush_inc && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

    always_comb begin
        state_nx     = state;
        drain_nx     = drain_cnt;
        ended_nx     = ended;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        halted       = 1'b0;
        // While reset is held the outputs stay at free-running values
        if (reset) begin
            unique case (state)
                RUN, STEP: begin
                    if (mem_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        flush_inc    = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end
                    if (state == STEP) begin
                        state_nx = HALTED;
                        if (wb_end) ended_nx = 1'b1;
                    end else if (wb_end) begin
                        state_nx = HALTED;
                        ended_nx = 1'b1;
                    end else if (dbg_halt_req) begin
                        state_nx = DRAIN;
                        drain_nx = DRAIN_INIT;
                    end
                end
                DRAIN: begin
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                    if (mem_branch_taken) begin
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        flush_inc    = 1'b1;
                    end
                    if (wb_end) begin
                        state_nx = HALTED;
                        ended_nx = 1'b1;
                        drain_nx = 3'd0;
                    end else if (drain_cnt <= 3'd1) begin
                        state_nx = HALTED;
                        drain_nx = 3'd0;
                    end else begin
                        drain_nx = drain_cnt - 3'd1;
                    end
                end
                HALTED: begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    mem_wb_en = 1'b0;
                    halted    = 1'b1;
                    if (!ended) begin
                        if (dbg_resume)    state_nx = RUN;
                        else if (dbg_step) state_nx = STEP;
                    end
                end
                default: state_nx = RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: hazard vector table plus
// hand-written halt/step/resume, end-of-program, reset and saturation runs.
module tb_pipeline_sequencer;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_uses_rs2 = 0, ex_mem_read = 0, mem_branch_taken = 0;
    logic wb_end = 0, dbg_halt_req = 0, dbg_step = 0, dbg_resume = 0;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, halted, ended;
    logic [CNT_W-1:0] stall_count, flush_count;

    int checks = 0;
    int errors = 0;

    // {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem flush, halted}
    localparam logic [8:0] O_NORM  = 9'b11111_000_0;
    localparam logic [8:0] O_STALL = 9'b00111_010_0;
    localparam logic [8:0] O_BR    = 9'b11111_111_0;
    localparam logic [8:0] O_DRAIN = 9'b01111_100_0;
    localparam logic [8:0] O_DRBR  = 9'b01111_111_0;
    localparam logic [8:0] O_HALT  = 9'b00000_000_1;

    pipeline_sequencer #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_branch_taken(mem_branch_taken), .wb_end(wb_end),
        .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step),
        .dbg_resume(dbg_resume),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .halted(halted), .ended(ended),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush, halted};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs2 = 0;
        ex_mem_read = 0; mem_branch_taken = 0; wb_end = 0;
        dbg_halt_req = 0; dbg_step = 0; dbg_resume = 0;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       uses2, rd_en, br;
        logic [8:0] exp_o;
        int         exp_st, exp_fl;
    } vec_t;

    vec_t vt[7];

    initial begin
        vt[0] = '{5, 0, 5, 0, 1, 0, O_STALL, 1, 0};
        vt[1] = '{0, 0, 0, 0, 1, 0, O_NORM,  1, 0};
        vt[2] = '{3, 7, 7, 0, 1, 0, O_NORM,  1, 0};
        vt[3] = '{3, 7, 7, 1, 1, 0, O_STALL, 2, 0};
        vt[4] = '{5, 0, 5, 0, 1, 1, O_BR,    2, 1};
        vt[5] = '{5, 0, 5, 0, 0, 0, O_NORM,  2, 1};
        vt[6] = '{0, 0, 0, 0, 0, 1, O_BR,    2, 2};

        // Reset held with a load-use pattern on the inputs
        id_rs1 = 5; ex_rd = 5; ex_mem_read = 1;
        #12;
        check("reset_outs", 32'(outs()), 32'(O_NORM));
        check("reset_ended", 32'(ended), 0);
        check("reset_cnt", {stall_count, flush_count}, 0);
        clear_inputs();
        to_neg();
        reset = 1;

        foreach (vt[i]) begin
            to_neg();
            id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2; ex_rd = vt[i].rd;
            id_uses_rs2 = vt[i].uses2; ex_mem_read = vt[i].rd_en;
            mem_branch_taken = vt[i].br;
            #1;
            check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vt[i].exp_o));
            @(posedge clk); #1;
            check($sformatf("vec%0d_stall", i), 32'(stall_count), vt[i].exp_st);
            check($sformatf("vec%0d_flush", i), 32'(flush_count), vt[i].exp_fl);
        end
        clear_inputs();

        // Debug halt: RUN cycle, 3 drain cycles (branch in the second), HALTED
        to_neg();
        dbg_halt_req = 1;
        #1 check("halt_req_run", 32'(outs()), 32'(O_NORM));
        for (int i = 0; i < 3; i++) begin
            to_neg();
            mem_branch_taken = (i == 1);
            #1 check($sformatf("drain%0d", i), 32'(outs()),
                     32'(i == 1 ? O_DRBR : O_DRAIN));
        end
        to_neg();
        mem_branch_taken = 0;
        #1 check("halted", 32'(outs()), 32'(O_HALT));
        check("drain_br_flush", 32'(flush_count), 3);
        dbg_halt_req = 0;

        // Step: one RUN-like cycle (with a stall hit), then HALTED again
        to_neg();
        dbg_step = 1;
        to_neg();
        dbg_step = 0;
        id_rs1 = 9; ex_rd = 9; ex_mem_read = 1;
        #1 check("step_outs", 32'(outs()), 32'(O_STALL));
        to_neg();
        clear_inputs();
        #1 check("step_back", 32'(outs()), 32'(O_HALT));
        check("step_stall", 32'(stall_count), 3);
        to_neg();
        #1 check("still_halted", 32'(outs()), 32'(O_HALT));

        // Resume and step together: resume wins
        dbg_resume = 1; dbg_step = 1;
        to_neg();
        dbg_resume = 0; dbg_step = 0;
        #1 check("resume_run", 32'(outs()), 32'(O_NORM));
        to_neg();
        #1 check("resume_stays", 32'(outs()), 32'(O_NORM));

        // End of program wins over halt request; resume ignored
        wb_end = 1; dbg_halt_req = 1;
        to_neg();
        clear_inputs();
        #1 check("end_halt", 32'(outs()), 32'(O_HALT));
        check("end_flag", 32'(ended), 1);
        dbg_resume = 1;
        to_neg();
        dbg_step = 1;
        to_neg();
        dbg_resume = 0; dbg_step = 0;
        #1 check("end_sticky", 32'(outs()), 32'(O_HALT));
        check("end_sticky_flag", 32'(ended), 1);

        // Asynchronous reset away from the clock edge
        #2 reset = 0;
        #1 check("areset_outs", 32'(outs()), 32'(O_NORM));
        check("areset_ended", 32'(ended), 0);
        check("areset_cnt", {stall_count, flush_count}, 0);
        to_neg();
        reset = 1;

        // Reset mid-drain discards the drain, DRAIN ends via wb_end otherwise
        dbg_halt_req = 1;
        to_neg();
        dbg_halt_req = 0;
        #1 check("drain2", 32'(outs()), 32'(O_DRAIN));
        #1 reset = 0;
        #1 check("drain_reset", 32'(outs()), 32'(O_NORM));
        to_neg();
        reset = 1;
        to_neg();
        #1 check("post_drain_reset", 32'(outs()), 32'(O_NORM));
        dbg_halt_req = 1;
        to_neg();
        dbg_halt_req = 0;
        wb_end = 1;
        to_neg();
        wb_end = 0;
        #1 check("drain_end", 32'(outs()), 32'(O_HALT));
        check("drain_end_flag", 32'(ended), 1);
        #1 reset = 0;
        to_neg();
        reset = 1;

        // Saturation of the stall counter
        id_rs1 = 4; ex_rd = 4; ex_mem_read = 1;
        repeat (65540) @(posedge clk);
        #1 check("stall_sat", 32'(stall_count), 32'hFFFF);
        check("sat_outs", 32'(outs()), 32'(O_STALL));
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Central sequencing controller for the 5-stage pipelined core (IF, ID, EX, MEM, WB). It drives the PC enable and the enable and flush inputs of the four pipeline registers. It resolves load-use hazards, flushes the pipeline on taken branches resolved in MEM, and stops the core when the end-of-program bubble reaches WB. It also provides a debug halt/step/resume sequence and saturating stall/flush statistics counters.

Parameters:
DRAIN_CYCLES, 3, number of bubble-insert cycles after a debug halt request before entering HALTED (1..7)
CNT_W, 16, width of the stall and flush statistics counters

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
id_rs1  input  5  rs1 field of the instruction in ID
id_rs2  input  5  rs2 field of the instruction in ID
id_uses_rs2  input  1  ID instruction reads rs2 (R-type, store, branch)
ex_mem_read  input  1  instruction in EX is a load
ex_rd  input  5  rd field of the instruction in EX
mem_branch_taken  input  1  branch in MEM stage is taken (branch & zero)
wb_end  input  1  end-of-program (all-zero) instruction is in WB
dbg_halt_req  input  1  debug halt request, level
dbg_step  input  1  single-cycle advance while halted, pulse
dbg_resume  input  1  leave HALTED, pulse
pc_en  output  1  PC load enable
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  pipeline register enables
if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  synchronous clear of the register at the next edge
halted  output  1  core is stopped
ended  output  1  sticky: program end reached
stall_count  output  CNT_W  load-use stall cycles, saturating
flush_count  output  CNT_W  taken-branch flush events, saturating

Behaviour:
- Reset (reset=0, asynchronous): state=RUN, ended=0, drain counter=0, both statistics counters=0.
- Outputs during reset: all enables=1, all flushes=0, halted=0.
- States: RUN, DRAIN, HALTED, STEP. All outputs below are combinational from the current state and current inputs. Counters and state update on the rising clk edge.
- load_use = ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- RUN or STEP, priority order:
  - mem_branch_taken: pc_en=1; if_id_flush=id_ex_flush=ex_mem_flush=1; all enables=1; flush_count+1. A load_use asserted in the same cycle is ignored and not counted.
  - else load_use: pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en=mem_wb_en=1; stall_count+1. This gives a 1-cycle bubble.
  - else: all enables=1, no flushes.
- RUN transitions:
  - wb_end=1 -> HALTED and set ended=1. wb_end has priority over dbg_halt_req.
  - dbg_halt_req=1 -> DRAIN and load the drain counter with DRAIN_CYCLES.
- DRAIN:
  - pc_en=0, if_id_flush=1; the other enables=1, so downstream stages keep retiring.
  - The counter decrements each cycle; on the cycle it reaches 1 -> HALTED.
  - A mem_branch_taken during DRAIN still asserts all three flushes and increments flush_count, but pc_en stays 0.
  - A wb_end during DRAIN sets ended=1 and goes to HALTED immediately.
- HALTED:
  - All enables=0, all flushes=0, halted=1.
  - dbg_resume=1 and ended=0 -> RUN.
  - else dbg_step=1 and ended=0 -> STEP.
  - While ended=1 only reset leaves HALTED.
- STEP:
  - Exactly one cycle of RUN-equivalent outputs (hazard rules apply, counters update); halted=0.
  - Next state is HALTED, or HALTED with ended=1 if wb_end=1.
- Simultaneous dbg_resume and dbg_step in HALTED: resume wins.
- Counters: saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-DRAIN or mid-STEP: immediate return to RUN values, with no partial drain carried over.

Test Plan:
- Load x5 in EX (ex_mem_read=1, ex_rd=5) with id_rs1=5 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_count=1. Repeat with ex_rd=0 -> no stall.
- Load-use on rs2 with id_uses_rs2=0 -> no stall; same with id_uses_rs2=1 -> stall.
- mem_branch_taken=1 together with a load_use hit -> all three flushes=1, pc_en=1; flush_count=1, stall_count unchanged.
- dbg_halt_req held with DRAIN_CYCLES=3 -> pc_en=0 and if_id_flush=1 for exactly 3 cycles, then halted=1 with all enables=0.
- While HALTED: dbg_step pulse -> exactly 1 cycle with enables=1, then halted=1 again. dbg_resume -> RUN.
- wb_end=1 in RUN -> halted=1, ended=1 next cycle; dbg_resume ignored; async reset=0 mid-cycle -> immediately enables=1, halted=0, ended=0, counters=0.
- Force 65536 stalls -> stall_count holds at 0xFFFF.
